immgen_pipe: RTL



---
 rtl/immgen_pkg.sv | 40 ++++
 rtl/immgen_dec.sv | 86 ++++++++
 rtl/immgen_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/immgen_pkg.sv
// ---------------------------------------------------------------------------
// immgen_pkg
// Shared types for the pipelined RISC-V immediate generator.
//   imm_fmt_e   : format tag attached to every decoded immediate
//   OPC_*       : base opcodes recognised by the decoder
//   imm_entry_t : one decoded result {imm, fmt, illegal}; imm is carried at
//                 the widest legal XLEN and narrowed by the consumer
// ---------------------------------------------------------------------------
package immgen_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } imm_fmt_e;

   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   localparam int IMM_W = 64;

   typedef struct packed {
      logic [IMM_W-1:0] imm;
      imm_fmt_e         fmt;
      logic             illegal;
   } imm_entry_t;

endpackage

// File: rtl/immgen_dec.sv
// ---------------------------------------------------------------------------
// immgen_dec
// Purely combinational immediate decode of one 32-bit instruction.
//   instr_i : raw instruction
//   entry_o : sign-extended immediate, format tag and illegal flag
// XLEN only decides whether OP-IMM-32 is legal; the immediate is always
// produced sign-extended to the full entry width.
// Macro IMMGEN_CSR_EN: when defined, CSR-immediate forms of SYSTEM decode as
// FMT_Z (zero-extended uimm) and the rest of SYSTEM as I-format; otherwise
// SYSTEM is illegal.
// ---------------------------------------------------------------------------
module immgen_dec
   import immgen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0] instr_i,
   output imm_entry_t  entry_o
);

   logic signed [IMM_W-1:0] imm_i;
   logic signed [IMM_W-1:0] imm_s;
   logic signed [IMM_W-1:0] imm_b;
   logic signed [IMM_W-1:0] imm_u;
   logic signed [IMM_W-1:0] imm_j;

   assign imm_i = {{(IMM_W-12){instr_i[31]}}, instr_i[31:20]};
   assign imm_s = {{(IMM_W-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b = {{(IMM_W-13){instr_i[31]}}, instr_i[31], instr_i[7],
                   instr_i[30:25], instr_i[11:8], 1'b0};
   assign imm_u = {{(IMM_W-32){instr_i[31]}}, instr_i[31:12], 12'b0};
   assign imm_j = {{(IMM_W-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                   instr_i[20], instr_i[30:21], 1'b0};

   always_comb begin
      entry_o         = '0;
      entry_o.fmt     = FMT_NONE;
      entry_o.illegal = 1'b0;
      case (instr_i[6:0])
         OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
            entry_o.imm = imm_i;
            entry_o.fmt = FMT_I;
         end
         OPC_OPIMM32: begin
            if (XLEN == 64) begin
               entry_o.imm = imm_i;
               entry_o.fmt = FMT_I;
            end else begin
               entry_o.illegal = 1'b1;
            end
         end
         OPC_STORE: begin
            entry_o.imm = imm_s;
            entry_o.fmt = FMT_S;
         end
         OPC_BRANCH: begin
            entry_o.imm = imm_b;
            entry_o.fmt = FMT_B;
         end
         OPC_LUI, OPC_AUIPC: begin
            entry_o.imm = imm_u;
            entry_o.fmt = FMT_U;
         end
         OPC_JAL: begin
            entry_o.imm = imm_j;
            entry_o.fmt = FMT_J;
         end
`ifdef IMMGEN_CSR_EN
         OPC_SYSTEM: begin
            // funct3[2] selects the CSR*I forms whose rs1 field is a uimm
            if (instr_i[14]) begin
               entry_o.imm = {{(IMM_W-5){1'b0}}, instr_i[19:15]};
               entry_o.fmt = FMT_Z;
            end else begin
               entry_o.imm = imm_i;
               entry_o.fmt = FMT_I;
            end
         end
`endif
         default: begin
            entry_o.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/immgen_pipe.sv
// ---------------------------------------------------------------------------
// immgen_pipe
// Pipelined immediate generator: decode ahead of a DEPTH-entry output FIFO.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   flush_i              : synchronous FIFO clear, overrides push/pop
//   in_valid_i/in_ready_o: instruction handshake (ready from state only)
//   instr_i              : raw instruction
//   out_valid_o/out_ready_i : FIFO head handshake
//   imm_o, fmt_o, illegal_o : head fields, reset values while empty
//   illegal_cnt_o        : saturating count of accepted illegal opcodes
// Macro IMMGEN_CSR_EN enables CSR-immediate decode (see immgen_dec).
// ---------------------------------------------------------------------------
module immgen_pipe
   import immgen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      instr_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  imm_o,
   output logic [2:0]       fmt_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] illegal_cnt_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   imm_entry_t       dec_p0;
   imm_entry_t       mem [DEPTH];
   imm_entry_t       head_p1;
   logic [IMM_W-1:0] head_imm_p1;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] count;
   logic [CNT_W-1:0] ill_cnt;
   logic             vld_p1;
   logic             push;
   logic             pop;

   // stage p0: combinational decode of the incoming instruction
   immgen_dec #(.XLEN(XLEN)) u_dec (
      .instr_i (instr_i),
      .entry_o (dec_p0)
   );

   assign in_ready_o = (count < OCC_W'(DEPTH));
   assign vld_p1     = (count != '0);
   assign push       = in_valid_i && in_ready_o;
   assign pop        = vld_p1 && out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ill_cnt <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
         if (push && dec_p0.illegal) ill_cnt <= sat_inc(ill_cnt);
      end
   end

   // FIFO storage holds data only; emptiness is tracked by count
   always_ff @(posedge clk_i) begin
      if (push && !flush_i) mem[wr_ptr] <= dec_p0;
   end

   // stage p1: FIFO head, forced to reset values while empty
   assign head_p1     = mem[rd_ptr];
   assign head_imm_p1 = head_p1.imm;

   assign out_valid_o   = vld_p1;
   assign imm_o         = vld_p1 ? XLEN'(head_imm_p1) : '0;
   assign fmt_o         = vld_p1 ? head_p1.fmt : FMT_NONE;
   assign illegal_o     = vld_p1 && head_p1.illegal;
   assign illegal_cnt_o = ill_cnt;

endmodule
